// File: rtl/sync_pkg.sv
// ----------------------------------------------------------------------------
// sync_pkg
// Shared constants for the clock-domain-crossing helpers.
//   DATA_SYNC_BUS_WIDTH : default width of the data bus handled by data_sync
//   DATA_SYNC_STAGES    : default depth of the enable synchronizer chain
// sync_cfg_ok() reports whether a width/depth pair is a legal configuration.
// ----------------------------------------------------------------------------
package sync_pkg;

    localparam int DATA_SYNC_BUS_WIDTH = 8;
    localparam int DATA_SYNC_STAGES    = 2;

    // Fewer than two stages gives no metastability protection at all.
    function automatic bit sync_cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 2);
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// ----------------------------------------------------------------------------
// sync_ff_chain
// Plain multi-flop synchronizer. Every stage is cleared by reset.
// Parameters:
//   WIDTH      : number of independent bits carried through the chain
//   NUM_STAGES : flop depth (must be >= 2)
// Ports:
//   i_clk   : destination clock, rising edge
//   i_rst   : asynchronous, active-low reset
//   i_async : input from a foreign clock domain
//   o_sync  : output of the last stage
// ----------------------------------------------------------------------------
module sync_ff_chain
    import sync_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int NUM_STAGES = DATA_SYNC_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    if (!sync_cfg_ok(WIDTH, NUM_STAGES)) begin : g_bad_cfg
        $error("sync_ff_chain: WIDTH must be >= 1 and NUM_STAGES >= 2");
    end

    logic [NUM_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [NUM_STAGES-1:0][WIDTH-1:0] stage_d;

    // Stage 0 samples the asynchronous input; each later stage copies its
    // predecessor.
    always_comb begin
        stage_d = {stage_q[NUM_STAGES-2:0], i_async};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_sync = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// ----------------------------------------------------------------------------
// data_sync
// Moves a multi-bit bus into the i_clk domain. Only the single-bit enable is
// synchronized. Its synchronized rising edge produces a one-cycle strobe, and
// on that strobe the bus, which the source holds stable, is captured.
// Optional feature: define DATA_SYNC_ACK_EN to add the o_ack output for a
// four-phase handshake back to the source.
// Parameters:
//   BUS_WIDTH  : data bus width (>= 1)
//   NUM_STAGES : enable synchronizer depth (>= 2)
// Ports:
//   i_clk          : destination clock, rising edge
//   i_rst          : asynchronous, active-low reset
//   i_unsync_bus   : source-domain data, held stable while i_bus_enable is high
//   i_bus_enable   : source-domain level that marks valid data
//   o_sync_bus     : captured copy of the bus
//   o_enable_pulse : one-cycle strobe, coincident with a new o_sync_bus value
//   o_ack          : (DATA_SYNC_ACK_EN only) high from the capture until the
//                    synchronized enable goes low
// ----------------------------------------------------------------------------
module data_sync
    import sync_pkg::*;
#(
    parameter int BUS_WIDTH  = DATA_SYNC_BUS_WIDTH,
    parameter int NUM_STAGES = DATA_SYNC_STAGES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BUS_WIDTH-1:0] i_unsync_bus,
    input  logic                 i_bus_enable,
`ifdef DATA_SYNC_ACK_EN
    output logic                 o_ack,
`endif
    output logic [BUS_WIDTH-1:0] o_sync_bus,
    output logic                 o_enable_pulse
);

    if (!sync_cfg_ok(BUS_WIDTH, NUM_STAGES)) begin : g_bad_cfg
        $error("data_sync: BUS_WIDTH must be >= 1 and NUM_STAGES >= 2");
    end

    logic                 sync_en;
    logic                 pulse_gen;
    logic                 sync_en_d_q, sync_en_d_d;
    logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
    logic                 enable_pulse_q, enable_pulse_d;

    sync_ff_chain #(
        .WIDTH      (1),
        .NUM_STAGES (NUM_STAGES)
    ) u_en_chain (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_bus_enable),
        .o_sync  (sync_en)
    );

    // Rising-edge detect on the synchronized enable: a long-held enable gives
    // a single strobe, and after reset a still-high enable counts as new.
    assign pulse_gen = sync_en & ~sync_en_d_q;

    always_comb begin
        sync_en_d_d    = sync_en;
        enable_pulse_d = pulse_gen;
        sync_bus_d     = sync_bus_q;
        if (pulse_gen) begin
            sync_bus_d = i_unsync_bus;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_en_d_q    <= 1'b0;
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
        end else begin
            sync_en_d_q    <= sync_en_d_d;
            sync_bus_q     <= sync_bus_d;
            enable_pulse_q <= enable_pulse_d;
        end
    end

    assign o_sync_bus     = sync_bus_q;
    assign o_enable_pulse = enable_pulse_q;

`ifdef DATA_SYNC_ACK_EN
    logic ack_q, ack_d;

    // Acknowledge rises with the capture and stays up until the source's
    // enable drop has made it through the synchronizer.
    always_comb begin
        ack_d = ack_q;
        if (pulse_gen) begin
            ack_d = 1'b1;
        end else if (!sync_en) begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign o_ack = ack_q;
`endif

endmodule

// File: tb/tb_data_sync.sv
// ----------------------------------------------------------------------------
// tb_data_sync
// Directed bench for data_sync. A two-stage instance is checked by a
// scoreboard of expected (data, cycle) strobes; a four-stage instance shares
// the stimulus and is checked directly on its latency.
// Define DATA_SYNC_ACK_EN to also check o_ack.
// ----------------------------------------------------------------------------
module tb_data_sync;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus;
    logic       en;

    logic [7:0] sync_bus;
    logic       pulse;
    logic [7:0] deep_bus;
    logic       deep_pulse;
`ifdef DATA_SYNC_ACK_EN
    logic       ack;
    logic       deep_ack;
`endif

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2)) u_dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_unsync_bus   (bus),
        .i_bus_enable   (en),
`ifdef DATA_SYNC_ACK_EN
        .o_ack          (ack),
`endif
        .o_sync_bus     (sync_bus),
        .o_enable_pulse (pulse)
    );

    data_sync #(.BUS_WIDTH(8), .NUM_STAGES(4)) u_deep (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_unsync_bus   (bus),
        .i_bus_enable   (en),
`ifdef DATA_SYNC_ACK_EN
        .o_ack          (deep_ack),
`endif
        .o_sync_bus     (deep_bus),
        .o_enable_pulse (deep_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] data, input int cycle);
        exp_t e;
        e.data  = data;
        e.cycle = cycle;
        exp_q.push_back(e);
    endtask

    // Every strobe of the two-stage instance must match the oldest expected
    // transfer in data and in cycle; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (pulse === 1'b1) begin
            chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_data", 32'(sync_bus), 32'(e.data));
                chk("pulse_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        en    = 1'b0;
        bus   = 8'h00;
        repeat (3) step();

        // Reset state
        chk("rst_bus", 32'(sync_bus), 32'h00);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_deep_bus", 32'(deep_bus), 32'h00);
        chk("rst_deep_pulse", 32'(deep_pulse), 32'h0);
`ifdef DATA_SYNC_ACK_EN
        chk("rst_ack", 32'(ack), 32'h0);
`endif
        rst_n = 1'b1;
        repeat (2) step();

        // Deep chain: enable sampled at edge k, update at k+4 (k+2 shallow)
        bus = 8'hF0;
        en  = 1'b1;
        k   = cyc + 1;
        push_exp(8'hF0, k + 2);
        for (int i = 0; i <= 5; i++) begin
            step();
            if (i < 4) begin
                chk("deep_hold_bus", 32'(deep_bus), 32'h00);
                chk("deep_no_pulse", 32'(deep_pulse), 32'h0);
            end else if (i == 4) begin
                chk("deep_bus", 32'(deep_bus), 32'hF0);
                chk("deep_pulse", 32'(deep_pulse), 32'h1);
            end else begin
                chk("deep_pulse_once", 32'(deep_pulse), 32'h0);
                chk("deep_bus_held", 32'(deep_bus), 32'hF0);
            end
        end
        en = 1'b0;
        repeat (8) step();

        // Basic transfer: enable sampled at edge k, outputs at k+2
        bus = 8'hA5;
        en  = 1'b1;
        push_exp(8'hA5, cyc + 3);
        repeat (2) step();
        chk("basic_before", 32'(sync_bus), 32'hF0);
        step();
        chk("basic_bus", 32'(sync_bus), 32'hA5);
        chk("basic_pulse", 32'(pulse), 32'h1);
        step();
        chk("basic_pulse_1cyc", 32'(pulse), 32'h0);
        repeat (2) step();
        en = 1'b0;
        repeat (6) step();

        // Held enable: single strobe, bus changes afterwards ignored
        bus = 8'h3C;
        en  = 1'b1;
        push_exp(8'h3C, cyc + 3);
        repeat (20) step();
        chk("held_bus", 32'(sync_bus), 32'h3C);
        en  = 1'b0;
        bus = 8'hFF;
        repeat (5) step();
        chk("held_ignore_bus", 32'(sync_bus), 32'h3C);

        // Back-to-back with a three-cycle low gap
        bus = 8'h11;
        en  = 1'b1;
        push_exp(8'h11, cyc + 3);
        repeat (4) step();
        chk("b2b_first", 32'(sync_bus), 32'h11);
        en = 1'b0;
        repeat (3) step();
        bus = 8'h22;
        en  = 1'b1;
        push_exp(8'h22, cyc + 3);
        repeat (4) step();
        chk("b2b_second", 32'(sync_bus), 32'h22);
        en = 1'b0;
        repeat (6) step();

        // Reset after edge 2 of a transfer: outputs clear at once, no strobe
        bus = 8'h5A;
        en  = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_bus", 32'(sync_bus), 32'h00);
        chk("midrst_pulse", 32'(pulse), 32'h0);
        chk("midrst_deep_bus", 32'(deep_bus), 32'h00);
        repeat (3) step();
        chk("midrst_no_update", 32'(sync_bus), 32'h00);

        // Release with enable still high: one strobe after normal latency
        rst_n = 1'b1;
        push_exp(8'h5A, cyc + 3);
        repeat (2) step();
        chk("release_before", 32'(sync_bus), 32'h00);
`ifdef DATA_SYNC_ACK_EN
        chk("ack_low_before", 32'(ack), 32'h0);
`endif
        step();
        chk("release_bus", 32'(sync_bus), 32'h5A);
`ifdef DATA_SYNC_ACK_EN
        chk("ack_rise", 32'(ack), 32'h1);
`endif
        repeat (2) step();
        en = 1'b0;
        repeat (2) step();
`ifdef DATA_SYNC_ACK_EN
        chk("ack_still_high", 32'(ack), 32'h1);
`endif
        step();
`ifdef DATA_SYNC_ACK_EN
        chk("ack_fall", 32'(ack), 32'h0);
`endif
        repeat (6) step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sync.md
DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8: width of the data bus crossing into the i_clk domain.
REQ-002 SHALL have parameter NUM_STAGES, default 2: number of flops in the enable synchronizer chain.
REQ-003 SHALL have port i_clk, input, 1: destination-domain clock; all state on rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_unsync_bus, input, BUS_WIDTH: data from the source domain, unsynchronized.
REQ-006 SHALL have port i_bus_enable, input, 1: source-domain level, high while i_unsync_bus is valid and stable.
REQ-007 SHALL have port o_sync_bus, output, BUS_WIDTH: registered, captured copy of i_unsync_bus.
REQ-008 SHALL have port o_enable_pulse, output, 1: registered, one-cycle strobe marking a new o_sync_bus value.

Function
REQ-009 SHALL pass i_bus_enable through a NUM_STAGES-deep flop chain; the last stage is sync_en.
REQ-010 SHALL hold one further flop, sync_en_d, and form pulse_gen = sync_en AND NOT sync_en_d.
REQ-011 SHALL load i_unsync_bus into o_sync_bus on the edge where pulse_gen is 1, and hold o_sync_bus otherwise.
REQ-012 SHALL register o_enable_pulse <= pulse_gen, so the strobe is coincident with the new o_sync_bus value.
REQ-013 SHALL meet this latency: i_bus_enable sampled 1 at edge k gives o_sync_bus and o_enable_pulse updated at edge k+NUM_STAGES.
  - Example: NUM_STAGES=2, sampled at edge 1, outputs at edge 3.
REQ-014 SHALL produce exactly one o_enable_pulse per rising edge of sync_en, however long i_bus_enable stays high.
REQ-015 SHALL keep o_enable_pulse high for exactly one i_clk cycle per transfer.
REQ-016 SHALL generate a new pulse after i_bus_enable falls and rises again, provided it stays low at least NUM_STAGES+1 i_clk cycles.
  - Shorter low gaps: merging into one transfer is permitted.
REQ-017 SHALL hold o_sync_bus stable between pulses and ignore changes on i_unsync_bus while pulse_gen is 0.
REQ-018 SHALL leave o_sync_bus unspecified if i_unsync_bus changes during the sampling cycle; the source is required to hold it stable from enable rise until the synchronized acknowledgement.
REQ-019 SHALL reject NUM_STAGES < 2 or BUS_WIDTH < 1 with an elaboration-time error.

Reset
REQ-020 SHALL, while i_rst is 0, clear every chain stage, sync_en_d, o_sync_bus, o_enable_pulse (and o_ack if present) to 0 asynchronously.
REQ-021 SHALL, on reset release with i_bus_enable still high, treat the enable as a new rising edge and produce one pulse after the normal latency.
REQ-022 SHALL drop any transfer in flight when reset asserts mid-chain, with no pulse and no bus update.

Configuration
REQ-023 SHALL use macro DATA_SYNC_ACK_EN to compile in output o_ack (1 bit, registered).
  - With the macro: o_ack is set on the edge o_sync_bus loads and cleared on the first edge where sync_en is 0; the source domain synchronizes o_ack as a four-phase handshake.
  - Without the macro: port o_ack and its logic are absent, and all other behaviour is identical.

Structure
REQ-024 SHALL take default constants DATA_SYNC_BUS_WIDTH=8 and DATA_SYNC_STAGES=2 from shared package sync_pkg.
REQ-025 SHALL implement the enable chain as sub-module sync_ff_chain, with parameters WIDTH and NUM_STAGES, ports i_clk, i_rst, i_async, o_sync, and every stage reset to 0.

Verification
REQ-026 SHALL cover a basic transfer (NUM_STAGES=2): bus 8'hA5, enable rises before edge 1 -> o_sync_bus=8'hA5 and o_enable_pulse=1 at edge 3 only.
REQ-027 SHALL cover a held enable: enable high for 20 cycles with the bus stable at 8'h3C -> exactly one pulse, o_sync_bus stays 8'h3C.
REQ-028 SHALL cover back-to-back transfers: 8'h11, enable low 3 cycles, then 8'h22 -> two pulses, outputs 8'h11 then 8'h22, no extra pulses.
REQ-029 SHALL cover the deep chain: NUM_STAGES=4, bus 8'hF0 -> update at edge k+4; o_sync_bus holds its old value through edge k+3.
REQ-030 SHALL cover reset mid-operation: i_rst low at edge 2 of a transfer -> all outputs 0 at once; release with enable high -> one pulse NUM_STAGES edges later.
REQ-031 SHALL cover the handshake with DATA_SYNC_ACK_EN: o_ack rises with the pulse and falls NUM_STAGES+1 edges after enable drops; without the macro the port is absent.
